// File: rtl/cvcdu_derandomizer.sv
// CVCDU derandomizer for the LRPT receive chain.
// Accepts post-ASM CVCDU bytes, requests one PN noise byte per accepted byte
// from lfsr_8, pairs each data byte with its noise byte through two small
// FIFOs and emits the XOR with frame-boundary tags. Because the pairing is
// FIFO based, any fixed or variable lfsr_8 response latency is tolerated.
module cvcdu_derandomizer #(
  parameter int FRAME_BYTES = 1020,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  input  logic       frame_start_in,
  input  logic [7:0] noise_in,
  input  logic       noise_valid_in,
  output logic       cvcdu_new_out,
  output logic       noise_req_out,
  output logic [7:0] byte_out,
  output logic       byte_valid_out,
  output logic       frame_start_out,
  output logic       frame_end_out,
  output logic       overflow_out
);

  localparam int CNT_W = $clog2(FRAME_BYTES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OUT_W = PTR_W + 2;

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_BYTES - 1);
  localparam logic [PTR_W:0]   DEPTH_PTR = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Data FIFO entry: {byte, first flag, last flag}.
  logic [9:0]       dmem [FIFO_DEPTH];
  logic [PTR_W:0]   dwr;
  logic [PTR_W:0]   drd;
  logic [7:0]       nmem [FIFO_DEPTH];
  logic [PTR_W:0]   nwr;
  logic [PTR_W:0]   nrd;

  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] discard;

  logic             d_empty;
  logic             d_full;
  logic             n_empty;
  logic             pop_raw;
  logic             pop;
  logic             d_room;
  logic             want;
  logic             accept;
  logic             drop;
  logic             abort;
  logic [CNT_W-1:0] idx;
  logic             is_last;
  logic             noise_ok;
  logic             noise_push;
  logic [OUT_W-1:0] outstanding_nxt;
  logic [9:0]       d_head;
  logic [7:0]       n_head;

  logic [7:0]       byte_p1;
  logic             vld_p1;
  logic             first_p1;
  logic             last_p1;

  assign d_empty = (dwr == drd);
  assign d_full  = ((dwr - drd) == DEPTH_PTR);
  assign n_empty = (nwr == nrd);
  assign d_head  = dmem[drd[PTR_W-1:0]];
  assign n_head  = nmem[nrd[PTR_W-1:0]];

  // A pop on a full data FIFO frees a slot for a push in the same cycle.
  assign pop_raw = !d_empty && !n_empty;
  assign d_room  = !d_full || pop_raw;

  // Bytes only count inside a frame or when they open one.
  assign want    = byte_valid_in && ((state == IN_FRAME) || frame_start_in);
  assign accept  = want && d_room;
  assign drop    = want && !d_room;

  // A frame start inside a frame abandons the old frame entirely.
  assign abort   = accept && frame_start_in && (state == IN_FRAME);
  assign pop     = pop_raw && !abort;

  assign idx     = frame_start_in ? '0 : cnt;
  assign is_last = (idx == LAST_IDX);

  // Noise with nothing requested is stray and ignored; noise belonging to an
  // aborted frame is swallowed while discard is non-zero.
  assign noise_ok   = noise_valid_in && (outstanding != '0);
  assign noise_push = noise_ok && (discard == '0) && !abort;

  // A request leaving this cycle still belongs to the old frame on abort,
  // so it is included in the count of responses to throw away.
  assign outstanding_nxt = outstanding + OUT_W'(noise_req_out) - OUT_W'(noise_ok);

  // Frame tracking: next state and byte index.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (accept) begin
      if (is_last) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        state_nxt = IN_FRAME;
        cnt_nxt   = idx + CNT_W'(1);
      end
    end
  end

  // Frame tracking state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FIFO pointers; an abort empties both FIFOs and keeps only the new byte.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dwr <= '0;
      drd <= '0;
      nwr <= '0;
      nrd <= '0;
    end else if (abort) begin
      drd <= dwr;
      dwr <= dwr + (PTR_W + 1)'(1);
      nrd <= nwr;
    end else begin
      if (accept)     dwr <= dwr + (PTR_W + 1)'(1);
      if (pop)        drd <= drd + (PTR_W + 1)'(1);
      if (noise_push) nwr <= nwr + (PTR_W + 1)'(1);
      if (pop)        nrd <= nrd + (PTR_W + 1)'(1);
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk_in) begin
    if (accept)     dmem[dwr[PTR_W-1:0]] <= {byte_in, frame_start_in, is_last};
    if (noise_push) nmem[nwr[PTR_W-1:0]] <= noise_in;
  end

  // Outstanding noise requests and responses still to be discarded.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (abort)
        discard <= outstanding_nxt;
      else if (noise_ok && (discard != '0))
        discard <= discard - OUT_W'(1);
    end
  end

  // One registered noise request per accepted byte; PN restart on byte 0.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      noise_req_out <= 1'b0;
      cvcdu_new_out <= 1'b0;
    end else begin
      noise_req_out <= accept;
      cvcdu_new_out <= accept && frame_start_in;
    end
  end

  // Sticky overflow flag, cleared when a new frame is accepted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      overflow_out <= 1'b0;
    else if (accept && frame_start_in)
      overflow_out <= 1'b0;
    else if (drop)
      overflow_out <= 1'b1;
  end

  // Stage p1: XOR of paired heads, tagged with the data FIFO frame flags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      byte_p1  <= '0;
    end else begin
      vld_p1   <= pop;
      first_p1 <= pop && d_head[1];
      last_p1  <= pop && d_head[0];
      if (pop)
        byte_p1 <= d_head[9:2] ^ n_head;
    end
  end

  assign byte_out        = byte_p1;
  assign byte_valid_out  = vld_p1;
  assign frame_start_out = first_p1;
  assign frame_end_out   = last_p1;

endmodule

// File: tb/tb_cvcdu_derandomizer.sv
// Directed bench for cvcdu_derandomizer with a behavioural lfsr_8 responder.
module tb_cvcdu_derandomizer;

  logic       clk_in;
  logic       rst_in;
  logic [7:0] byte_in;
  logic       byte_valid_in;
  logic       frame_start_in;
  logic [7:0] noise_in;
  logic       noise_valid_in;
  logic       cvcdu_new_out;
  logic       noise_req_out;
  logic [7:0] byte_out;
  logic       byte_valid_out;
  logic       frame_start_out;
  logic       frame_end_out;
  logic       overflow_out;

  cvcdu_derandomizer #(.FRAME_BYTES(1020), .FIFO_DEPTH(8)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .byte_in         (byte_in),
    .byte_valid_in   (byte_valid_in),
    .frame_start_in  (frame_start_in),
    .noise_in        (noise_in),
    .noise_valid_in  (noise_valid_in),
    .cvcdu_new_out   (cvcdu_new_out),
    .noise_req_out   (noise_req_out),
    .byte_out        (byte_out),
    .byte_valid_out  (byte_valid_out),
    .frame_start_out (frame_start_out),
    .frame_end_out   (frame_end_out),
    .overflow_out    (overflow_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // CCSDS PN generator x^8+x^7+x^5+x^3+1, all-ones seed, MSB first.
  // Returns {next window, output byte}.
  function automatic logic [15:0] pn_adv(input logic [7:0] w_in);
    logic [7:0] w;
    logic [7:0] b;
    logic       nb;
    w = w_in;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b  = {b[6:0], w[0]};
      nb = w[0] ^ w[3] ^ w[5] ^ w[7];
      w  = {nb, w[7:1]};
    end
    return {w, b};
  endfunction

  // Responder / monitor state.
  int         cyc = 0;
  int         lat = 3;
  logic       stall = 1'b0;
  logic       mode_const = 1'b0;
  logic [7:0] tx_pn = 8'hFF;
  logic [7:0] env_nb;
  int         due_q[$];
  logic [7:0] val_q[$];
  int         n_req = 0;
  int         n_new = 0;
  logic [7:0] out_b[$];
  logic       out_fs[$];
  logic       out_fe[$];
  int         out_cyc[$];

  // Behavioural lfsr_8 plus output monitor, sampled 1 time unit after the edge.
  initial begin
    noise_valid_in = 1'b0;
    noise_in       = 8'h00;
    forever begin
      @(posedge clk_in);
      #1;
      cyc++;
      if (noise_req_out) begin
        if (cvcdu_new_out) begin
          tx_pn = 8'hFF;
          n_new++;
        end
        {tx_pn, env_nb} = pn_adv(tx_pn);
        due_q.push_back(cyc + lat);
        val_q.push_back(mode_const ? 8'hA5 : env_nb);
        n_req++;
      end
      if (byte_valid_out) begin
        out_b.push_back(byte_out);
        out_fs.push_back(frame_start_out);
        out_fe.push_back(frame_end_out);
        out_cyc.push_back(cyc);
      end
      if (!stall && (due_q.size() > 0) && (due_q[0] <= cyc)) begin
        noise_valid_in = 1'b1;
        noise_in       = val_q.pop_front();
        void'(due_q.pop_front());
      end else begin
        noise_valid_in = 1'b0;
      end
    end
  end

  task automatic drive(input logic [7:0] b, input logic fs);
    @(negedge clk_in);
    byte_in        = b;
    byte_valid_in  = 1'b1;
    frame_start_in = fs;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      byte_valid_in  = 1'b0;
      frame_start_in = 1'b0;
    end
  endtask

  task automatic wait_out(input int n, input string tag);
    int k;
    k = 0;
    while ((out_b.size() < n) && (k < 5000)) begin
      @(posedge clk_in);
      k++;
    end
    @(negedge clk_in);
    chk(tag, out_b.size(), n);
  endtask

  int         base;
  int         fbase;
  int         req0;
  int         new0;
  int         errs;
  int         fs_n;
  int         fe_n;
  int         k;
  logic [7:0] pn;
  logic [7:0] e;
  logic [7:0] d;

  initial begin
    rst_in         = 1'b1;
    byte_in        = 8'h00;
    byte_valid_in  = 1'b0;
    frame_start_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_valid", byte_valid_out, 1'b0);
    chk("rst_fs", frame_start_out, 1'b0);
    chk("rst_fe", frame_end_out, 1'b0);
    chk("rst_ovf", overflow_out, 1'b0);
    chk("rst_new", cvcdu_new_out, 1'b0);
    chk("rst_req", noise_req_out, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;
    idle(2);

    // Full frame of zeros against the PN sequence.
    base = out_b.size();
    new0 = n_new;
    for (int i = 0; i < 1020; i++) drive(8'h00, i == 0);
    idle(1);
    wait_out(base + 1020, "t1_count");
    chk("t1_b0", out_b[base], 8'hFF);
    chk("t1_b1", out_b[base + 1], 8'h48);
    chk("t1_b2", out_b[base + 2], 8'h0E);
    chk("t1_b3", out_b[base + 3], 8'hC0);
    pn = 8'hFF; errs = 0; fs_n = 0; fe_n = 0;
    for (int i = 0; i < 1020; i++) begin
      {pn, e} = pn_adv(pn);
      if (out_b[base + i] !== e) errs++;
      fs_n += int'(out_fs[base + i]);
      fe_n += int'(out_fe[base + i]);
    end
    chk("t1_pn_errs", errs, 0);
    chk("t1_fs_first", out_fs[base], 1'b1);
    chk("t1_fe_last", out_fe[base + 1019], 1'b1);
    chk("t1_fs_n", fs_n, 1);
    chk("t1_fe_n", fe_n, 1);
    chk("t1_new_pulses", n_new - new0, 1);
    chk("t1_ovf", overflow_out, 1'b0);

    // Constant noise 0xA5 at latency 5, ramp data, no gaps.
    mode_const = 1'b1;
    lat = 5;
    base = out_b.size();
    for (int i = 0; i < 297; i++) drive(8'(i), i == 0);
    idle(1);
    wait_out(base + 297, "t2_count");
    errs = 0; fe_n = 0;
    for (int i = 0; i < 297; i++) begin
      if (out_b[base + i] !== (8'(i) ^ 8'hA5)) errs++;
      fe_n += int'(out_fe[base + i]);
    end
    chk("t2_data_errs", errs, 0);
    chk("t2_fs_first", out_fs[base], 1'b1);
    chk("t2_no_fe", fe_n, 0);
    chk("t2_no_gaps", out_cyc[base + 296] - out_cyc[base], 296);

    // Abort at index 300 with three requests outstanding.
    mode_const = 1'b0;
    lat = 3;
    stall = 1'b1;
    base = out_b.size();
    req0 = n_req;
    for (int i = 297; i < 300; i++) drive(8'(i), 1'b0);
    idle(2);
    chk("t3_req_before_abort", n_req - req0, 3);
    drive(8'h3C, 1'b1);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    idle(1);
    stall = 1'b0;
    wait_out(base + 3, "t3_count");
    chk("t3_b0", out_b[base], 8'hC3);
    chk("t3_b1", out_b[base + 1], 8'h48);
    chk("t3_b2", out_b[base + 2], 8'h0E);
    chk("t3_fs_first", out_fs[base], 1'b1);
    idle(10);
    chk("t3_no_extra", out_b.size(), base + 3);
    fbase = base;

    // Noise stalled: FIFO fills at 8, overflow set, drops not counted.
    stall = 1'b1;
    req0 = n_req;
    for (int i = 0; i < 20; i++) drive(8'h00, 1'b0);
    idle(3);
    chk("t4_ovf_set", overflow_out, 1'b1);
    chk("t4_req_n", n_req - req0, 8);
    chk("t4_no_out_stalled", out_b.size(), fbase + 3);
    stall = 1'b0;
    wait_out(fbase + 11, "t4_drain");
    for (int i = 0; i < 1009; i++) drive(8'h00, 1'b0);
    idle(1);
    wait_out(fbase + 1020, "t4_count");
    pn = 8'hFF; errs = 0; fe_n = 0;
    for (int i = 0; i < 1020; i++) begin
      {pn, e} = pn_adv(pn);
      d = (i == 0) ? 8'h3C : 8'h00;
      if (out_b[fbase + i] !== (d ^ e)) errs++;
      fe_n += int'(out_fe[fbase + i]);
    end
    chk("t4_frame_errs", errs, 0);
    chk("t4_fe_last", out_fe[fbase + 1019], 1'b1);
    chk("t4_fe_n", fe_n, 1);
    chk("t4_ovf_sticky", overflow_out, 1'b1);

    // Trailing bytes without frame start are ignored in IDLE.
    req0 = n_req;
    base = out_b.size();
    for (int i = 0; i < 10; i++) drive(8'h55, 1'b0);
    idle(8);
    chk("t5_no_req", n_req - req0, 0);
    chk("t5_no_out", out_b.size(), base);
    chk("t5_ovf_kept", overflow_out, 1'b1);

    // New frame clears overflow; reset mid-frame with 4 requests in flight.
    mode_const = 1'b1;
    stall = 1'b1;
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b0);
    chk("t6_ovf_clear", overflow_out, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    @(posedge clk_in);
    #2;
    chk("t6_req_before_rst", noise_req_out, 1'b1);
    rst_in = 1'b1;
    #1;
    chk("t6_rst_req", noise_req_out, 1'b0);
    chk("t6_rst_new", cvcdu_new_out, 1'b0);
    chk("t6_rst_valid", byte_valid_out, 1'b0);
    chk("t6_rst_byte", byte_out, 8'h00);
    chk("t6_rst_ovf", overflow_out, 1'b0);
    chk("t6_rst_fs_fe", {frame_start_out, frame_end_out}, 2'b00);
    chk("t6_pending", due_q.size(), 4);
    idle(3);
    rst_in = 1'b0;
    mode_const = 1'b0;
    idle(1);
    stall = 1'b0;
    base = out_b.size();
    k = 0;
    while ((due_q.size() > 0) && (k < 200)) begin
      @(posedge clk_in);
      k++;
    end
    idle(5);
    chk("t6_late_noise_no_out", out_b.size(), base);
    drive(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) drive(8'h00, 1'b0);
    idle(1);
    wait_out(base + 4, "t6_count");
    chk("t6_b0", out_b[base], 8'hFF);
    chk("t6_b1", out_b[base + 1], 8'h48);
    chk("t6_b2", out_b[base + 2], 8'h0E);
    chk("t6_b3", out_b[base + 3], 8'hC0);
    chk("t6_fs_first", out_fs[base], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
